vga_display_core: RTL

//  Parametrised successor to the fixed 640x480 VGA top: timing generator, N-object renderer and output pipeline.

---
 rtl/vga_display_core.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_display_core.sv
// Parametrised VGA timing generator, N-object square renderer and aligned output pipeline.
// Object updates are double-buffered and committed at the end of the last active line.
module vga_display_core #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned NUM_OBJ     = 2,
  parameter int unsigned OBJ_SIZE    = 8,
  parameter logic [11:0] BG_RGB      = 12'h000
) (
  input  logic                    CLK25MHZ,
  input  logic                    reset,
  input  logic                    upd_req,
  input  logic [10*NUM_OBJ-1:0]   obj_x,
  input  logic [10*NUM_OBJ-1:0]   obj_y,
  input  logic [12*NUM_OBJ-1:0]   obj_rgb,
  output logic                    upd_ack,
  output logic                    frame_start,
  output logic                    video_on,
  output logic [11:0]             rgb,
  output logic                    VGA_HS,
  output logic                    VGA_VS
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] OBJ_SZ    = 11'(OBJ_SIZE);

  logic [9:0] hcnt;
  logic [9:0] vcnt;

  // Active (displayed) and pending (next-frame) object sets.
  logic [9:0]  act_x   [NUM_OBJ];
  logic [9:0]  act_y   [NUM_OBJ];
  logic [11:0] act_rgb [NUM_OBJ];
  logic [9:0]  pnd_x   [NUM_OBJ];
  logic [9:0]  pnd_y   [NUM_OBJ];
  logic [11:0] pnd_rgb [NUM_OBJ];
  logic        pending;
  logic        commit;

  logic        hs_raw;
  logic        vs_raw;
  logic        von_raw;
  logic        fs_raw;
  logic [11:0] obj_col;
  logic [11:0] rgb_raw;
  logic [NUM_OBJ-1:0] hit;

  logic [11:0]            rgb_pipe [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] hs_pipe;
  logic [PIPE_STAGES-1:0] vs_pipe;
  logic [PIPE_STAGES-1:0] von_pipe;
  logic [PIPE_STAGES-1:0] fs_pipe;

  // Pixel and line counters.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  always_comb begin
    hs_raw  = (hcnt >= HS_START && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_raw  = (vcnt >= VS_START && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    von_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
    fs_raw  = (hcnt == 10'd0) && (vcnt == 10'd0);
    commit  = (hcnt == H_LAST) && (vcnt == V_ACT_LAST);
  end

  // 11-bit sums keep objects near the right/bottom edge clipped rather than wrapped.
  always_comb begin
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      hit[i] = ({1'b0, hcnt} >= {1'b0, act_x[i]}) &&
               ({1'b0, hcnt} <  ({1'b0, act_x[i]} + OBJ_SZ)) &&
               ({1'b0, vcnt} >= {1'b0, act_y[i]}) &&
               ({1'b0, vcnt} <  ({1'b0, act_y[i]} + OBJ_SZ));
    end
  end

  // Scan from the highest index down so the lowest hit index wins.
  always_comb begin
    obj_col = BG_RGB;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        obj_col = act_rgb[i];
      end
    end
    rgb_raw = von_raw ? obj_col : 12'h000;
  end

  // Update handshake: the commit consumes the old buffer even if upd_req lands on that cycle.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      upd_ack <= 1'b0;
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        act_x[i]   <= H_ACT;
        act_y[i]   <= '0;
        act_rgb[i] <= '0;
        pnd_x[i]   <= '0;
        pnd_y[i]   <= '0;
        pnd_rgb[i] <= '0;
      end
    end else begin
      upd_ack <= commit && pending;
      if (commit && pending) begin
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
          act_x[i]   <= pnd_x[i];
          act_y[i]   <= pnd_y[i];
          act_rgb[i] <= pnd_rgb[i];
        end
      end
      if (upd_req) begin
        pending <= 1'b1;
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
          pnd_x[i]   <= obj_x[10*i +: 10];
          pnd_y[i]   <= obj_y[10*i +: 10];
          pnd_rgb[i] <= obj_rgb[12*i +: 12];
        end
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Output pipeline: every pin-facing signal sees the same delay.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      hs_pipe  <= {PIPE_STAGES{~SYNC_POL}};
      vs_pipe  <= {PIPE_STAGES{~SYNC_POL}};
      von_pipe <= '0;
      fs_pipe  <= '0;
      for (int i = 0; i < int'(PIPE_STAGES); i++) begin
        rgb_pipe[i] <= '0;
      end
    end else begin
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      von_pipe[0] <= von_raw;
      fs_pipe[0]  <= fs_raw;
      rgb_pipe[0] <= rgb_raw;
      for (int i = 1; i < int'(PIPE_STAGES); i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        von_pipe[i] <= von_pipe[i-1];
        fs_pipe[i]  <= fs_pipe[i-1];
        rgb_pipe[i] <= rgb_pipe[i-1];
      end
    end
  end

  assign rgb         = rgb_pipe[PIPE_STAGES-1];
  assign VGA_HS      = hs_pipe[PIPE_STAGES-1];
  assign VGA_VS      = vs_pipe[PIPE_STAGES-1];
  assign video_on    = von_pipe[PIPE_STAGES-1];
  assign frame_start = fs_pipe[PIPE_STAGES-1];

endmodule
